// File: rtl/hazard_unit.sv
// hazard_unit: pipeline flush/hold/PC-select control.
// Handles load-use stalls, branch/jump redirects, precise traps for interrupts
// and undefined instructions, and eret. It also keeps saturating bubble and
// flush counters.
//
// state  | meaning
// RUN    | user mode, interrupts can be taken
// KERNEL | trap handler running, interrupts masked (they stay pending)
module hazard_unit #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rt,
  input  logic             ID_jump,
  input  logic             ID_exc,
  input  logic             ID_eret,
  input  logic             EX_MemRd,
  input  logic [4:0]       EX_rt,
  input  logic             EX_br_taken,
  input  logic             irq,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             flush_IF2ID,
  output logic             flush_ID2EX,
  output logic [2:0]       pc_sel,
  output logic             epc_we,
  output logic             irq_ack,
  output logic             kernel,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, KERNEL = 1'b1} stateT;

  localparam logic [2:0] SEL_PC4  = 3'b000;
  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JMP  = 3'b010;
  localparam logic [2:0] SEL_IRQ  = 3'b011;
  localparam logic [2:0] SEL_EXC  = 3'b100;
  localparam logic [2:0] SEL_EPC  = 3'b101;

  stateT                  state;
  stateT                  stateNext;
  logic                   irqPend;
  logic [SYNC_STAGES-1:0] irqSync;
  logic                   irqSyncDly;
  logic                   irqRise;
  logic                   loadUse;
  logic                   takeIrq;
  logic                   bubbleInc;
  logic                   flushInc;

  assign irqRise = irqSync[SYNC_STAGES-1] & ~irqSyncDly;
  assign loadUse = EX_MemRd && (EX_rt != 5'd0) &&
                   ((EX_rt == ID_rs) || (ID_use_rt && (EX_rt == ID_rt)));
  assign kernel  = (state == KERNEL);

  // Priority decode of the per-cycle control strobes; everything is gated low in reset.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    flush_IF2ID = 1'b0;
    flush_ID2EX = 1'b0;
    pc_sel      = SEL_PC4;
    epc_we      = 1'b0;
    irq_ack     = 1'b0;
    takeIrq     = 1'b0;
    bubbleInc   = 1'b0;
    flushInc    = 1'b0;
    stateNext   = state;
    if (reset) begin
      if (EX_br_taken) begin
        pc_sel      = SEL_BR;
        flush_IF2ID = 1'b1;
        flush_ID2EX = 1'b1;
        flushInc    = 1'b1;
      end else if (loadUse) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        flush_ID2EX = 1'b1;
        bubbleInc   = 1'b1;
      end else if (ID_exc) begin
        pc_sel      = SEL_EXC;
        flush_IF2ID = 1'b1;
        flush_ID2EX = 1'b1;
        epc_we      = 1'b1;
        stateNext   = KERNEL;
      end else if (irqPend && state == RUN) begin
        pc_sel      = SEL_IRQ;
        flush_IF2ID = 1'b1;
        flush_ID2EX = 1'b1;
        epc_we      = 1'b1;
        irq_ack     = 1'b1;
        takeIrq     = 1'b1;
        stateNext   = KERNEL;
      end else if (ID_eret && state == KERNEL) begin
        pc_sel      = SEL_EPC;
        flush_IF2ID = 1'b1;
        flush_ID2EX = 1'b1;
        stateNext   = RUN;
      end else if (ID_jump) begin
        pc_sel      = SEL_JMP;
        flush_IF2ID = 1'b1;
      end
    end
  end

  // Irq synchronizer, mode FSM, pending latch (set beats clear) and saturating counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irqSync    <= '0;
      irqSyncDly <= 1'b0;
      irqPend    <= 1'b0;
      state      <= RUN;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      irqSync    <= {irqSync[SYNC_STAGES-2:0], irq};
      irqSyncDly <= irqSync[SYNC_STAGES-1];
      irqPend    <= irqRise | (irqPend & ~takeIrq);
      state      <= stateNext;
      if (bubbleInc && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (flushInc && flush_cnt != '1)   flush_cnt  <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: random and directed stimulus against a behavioural model.
module tb_hazard_unit;
  localparam int S = 2;
  localparam int W = 4;
  localparam int CMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ID_rs, ID_rt, EX_rt;
  logic ID_use_rt, ID_jump, ID_exc, ID_eret, EX_MemRd, EX_br_taken, irq;
  logic pc_hold, ifid_hold, flush_IF2ID, flush_ID2EX, epc_we, irq_ack, kernel;
  logic [2:0] pc_sel;
  logic [W-1:0] bubble_cnt, flush_cnt;

  int total = 0;
  int bad = 0;

  // model state
  bit mKernel, mPend;
  bit hist[$];
  int mBubble, mFlush;
  logic [9:0] lastCtl;
  bit lastAck, lastHold;
  logic [2:0] lastSel;

  hazard_unit #(.SYNC_STAGES(S), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rt(ID_use_rt),
    .ID_jump(ID_jump), .ID_exc(ID_exc), .ID_eret(ID_eret), .EX_MemRd(EX_MemRd),
    .EX_rt(EX_rt), .EX_br_taken(EX_br_taken), .irq(irq), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .flush_IF2ID(flush_IF2ID), .flush_ID2EX(flush_ID2EX),
    .pc_sel(pc_sel), .epc_we(epc_we), .irq_ack(irq_ack), .kernel(kernel),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // irq value sampled k clock edges ago (k=1 is the most recent edge)
  function automatic bit histAgo(int k);
    if (k <= hist.size()) return hist[hist.size() - k];
    return 1'b0;
  endfunction

  task automatic clearInputs();
    ID_rs = 0; ID_rt = 0; EX_rt = 0; ID_use_rt = 0; ID_jump = 0; ID_exc = 0;
    ID_eret = 0; EX_MemRd = 0; EX_br_taken = 0;
  endtask

  // Called just after a rising edge with inputs set; checks one cycle and advances.
  task automatic step(input string tag);
    bit lu, hold, fI, fE, epc, ack, nk;
    logic [2:0] sel;
    logic [9:0] exp, got;
    hold = 0; fI = 0; fE = 0; epc = 0; ack = 0; sel = 3'd0; nk = mKernel;
    lu = EX_MemRd && EX_rt != 0 && (EX_rt == ID_rs || (ID_use_rt && EX_rt == ID_rt));
    #2;
    if (EX_br_taken) begin sel = 3'd1; fI = 1; fE = 1; end
    else if (lu) begin hold = 1; fE = 1; end
    else if (ID_exc) begin sel = 3'd4; fI = 1; fE = 1; epc = 1; nk = 1; end
    else if (mPend && !mKernel) begin sel = 3'd3; fI = 1; fE = 1; epc = 1; ack = 1; nk = 1; end
    else if (ID_eret && mKernel) begin sel = 3'd5; fI = 1; fE = 1; nk = 0; end
    else if (ID_jump) begin sel = 3'd2; fI = 1; end
    exp = {hold, hold, fI, fE, sel, epc, ack, mKernel};
    got = {pc_hold, ifid_hold, flush_IF2ID, flush_ID2EX, pc_sel, epc_we, irq_ack, kernel};
    checkEq({tag, "_ctl"}, 32'(got), 32'(exp));
    checkEq({tag, "_bub"}, 32'(bubble_cnt), 32'(mBubble));
    checkEq({tag, "_fls"}, 32'(flush_cnt), 32'(mFlush));
    lastCtl = got; lastAck = irq_ack; lastSel = pc_sel; lastHold = pc_hold;
    @(posedge clk);
    mPend = (histAgo(S) && !histAgo(S + 1)) || (mPend && !ack);
    mKernel = nk;
    if (EX_br_taken && mFlush < CMAX) mFlush++;
    if (!EX_br_taken && lu && mBubble < CMAX) mBubble++;
    hist.push_back(irq);
    if (hist.size() > 8) void'(hist.pop_front());
    #1;
  endtask

  // Drop reset mid-cycle with inputs still active, check outputs, then recover.
  task automatic resetDut(input string tag);
    #2;
    reset = 1'b0;
    #1;
    checkEq({tag, "_rstout"},
            32'({pc_hold, ifid_hold, flush_IF2ID, flush_ID2EX, pc_sel, epc_we, irq_ack, kernel}),
            32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkEq({tag, "_rstcnt"}, 32'({bubble_cnt, flush_cnt}), 32'd0);
    reset = 1'b1;
    hist.delete();
    mPend = 0; mKernel = 0; mBubble = 0; mFlush = 0;
  endtask

  initial begin
    int n;
    clearInputs();
    irq = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    resetDut("init");

    // T1 load-use stall, then EX_rt=0 does not stall
    EX_MemRd = 1; EX_rt = 5'd8; ID_rs = 5'd8;
    step("t1");
    checkEq("t1_hold", 32'(lastHold), 32'd1);
    checkEq("t1_bubcnt", 32'(bubble_cnt), 32'd1);
    EX_rt = 5'd0; ID_rs = 5'd0;
    step("t1z");
    checkEq("t1z_hold", 32'(lastHold), 32'd0);

    // T2 branch beats jump and load-use
    EX_MemRd = 1; EX_rt = 5'd3; ID_rt = 5'd3; ID_use_rt = 1; ID_jump = 1; EX_br_taken = 1;
    step("t2");
    checkEq("t2_sel", 32'(lastSel), 32'd1);
    checkEq("t2_flscnt", 32'(flush_cnt), 32'd1);
    clearInputs();

    // T3 interrupt latency, then a second irq while in kernel stays pending
    irq = 1;
    step("t3");
    irq = 0;
    n = 0;
    while (!lastAck && n < 10) begin
      n++;
      step("t3w");
    end
    checkEq("t3_latency", 32'(n), 32'(S + 1));
    step("t3k");
    checkEq("t3_kernel", 32'(kernel), 32'd1);
    irq = 1;
    step("t3b");
    irq = 0;
    for (int i = 0; i < 5; i++) step("t3p");
    checkEq("t3_noack", 32'(lastAck), 32'd0);

    // T4 eret returns to RUN and the pending irq is taken next cycle
    ID_eret = 1;
    step("t4");
    checkEq("t4_sel", 32'(lastSel), 32'd5);
    ID_eret = 0;
    step("t4a");
    checkEq("t4_ack", 32'(lastAck), 32'd1);
    checkEq("t4_asel", 32'(lastSel), 32'd3);

    // T5 exception in kernel, then exception under a stall
    ID_exc = 1;
    step("t5");
    checkEq("t5_sel", 32'(lastSel), 32'd4);
    checkEq("t5_kern", 32'(kernel), 32'd1);
    EX_MemRd = 1; EX_rt = 5'd5; ID_rs = 5'd5;
    step("t5s");
    checkEq("t5s_hold", 32'(lastHold), 32'd1);
    clearInputs();

    // T6 bubble counter saturation, then reset during a trap
    EX_MemRd = 1; EX_rt = 5'd9; ID_rs = 5'd9;
    for (int i = 0; i < CMAX + 4; i++) step("t6");
    checkEq("t6_sat", 32'(bubble_cnt), 32'(CMAX));
    clearInputs();
    ID_exc = 1;
    step("t6e");
    irq = 1;
    resetDut("t6r");
    irq = 0;
    clearInputs();
    step("t6post");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      EX_MemRd    = ($urandom_range(0, 9) < 3);
      EX_rt       = 5'($urandom_range(0, 3));
      ID_rs       = 5'($urandom_range(0, 3));
      ID_rt       = 5'($urandom_range(0, 3));
      ID_use_rt   = 1'($urandom_range(0, 1));
      EX_br_taken = ($urandom_range(0, 19) < 3);
      ID_exc      = ($urandom_range(0, 19) == 0);
      ID_eret     = ($urandom_range(0, 19) < 3);
      ID_jump     = ($urandom_range(0, 19) < 3);
      if ($urandom_range(0, 9) == 0) irq = ~irq;
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
